uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Parametrised next-generation UART transmitter for the MPSoC core-to-host debug/console path.
- Accepts words over a valid/ready stream into an internal FIFO and serialises them LSB-first as 8N1/8N2-style frames.
- Generalised data width, stop-bit count and FIFO depth; exact bit timing; back-to-back frames with no idle gap.
- One instance per core; output pin goes to the board UART pad mux.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s; DIV = CLK_FREQ/BAUD_RATE (integer, truncated), must be >= 2.
- DATA_W, 8, data bits per frame, legal 5..32.
- STOP_BITS, 1, stop bits per frame, legal 1 or 2.
- FIFO_DEPTH, 4, transmit FIFO entries, power of two, >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  producer has a word.
- s_data  in  DATA_W  word to send, bit 0 transmitted first.
- s_ready  out  1  FIFO can accept; transfer when s_valid && s_ready at a rising edge.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst high at an edge): tx=1, tx_busy=0, s_ready=1, fifo_level=0, FSM=IDLE, baud and bit counters=0, FIFO pointers cleared, contents discarded. Reset mid-frame aborts the frame; tx is 1 from the cycle after the reset edge.
- FIFO: s_ready = (fifo_level != FIFO_DEPTH), registered-output free. A push while full is impossible because s_ready=0, even if a pop occurs in the same cycle. Simultaneous push and pop with level < FIFO_DEPTH leaves the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE: when the FIFO is non-empty, pop the head into shift_reg, go to START, and drive tx=0 in the next cycle. Latency from an accepted push into an empty idle block to the tx falling edge is 2 cycles.
- Every bit holds tx for exactly DIV cycles. The baud counter runs 0..DIV-1 and the bit advances when it reaches DIV-1.
- START: 1 bit of 0, then DATA.
- DATA: DATA_W bits, shift_reg[0] first, then shift right. The bit counter counts 0..DATA_W-1.
- STOP: STOP_BITS bits of 1. At the end of the last stop bit:
  - FIFO non-empty: pop and enter START directly, so the next start bit follows immediately with no extra idle cycle.
  - FIFO empty: enter IDLE.
- Frame length is (1+DATA_W+STOP_BITS)*DIV cycles, plus DIV more with parity enabled.
- tx_busy = (FSM != IDLE) || (fifo_level != 0), registered; it falls on the cycle IDLE is entered with an empty FIFO.
- tx is driven from a register, so the line is glitch-free.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: adds parameter PARITY_ODD (default 0) and a PARITY state between DATA and STOP. The PARITY bit is the XOR of the data bits, inverted when PARITY_ODD=1, held for DIV cycles.
- Undefined: no PARITY state and no parity logic; the frame goes DATA -> STOP.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum uart_tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - a function uart_div(clk_freq, baud);
  - the localparam for the idle line level (1'b1).
- One sub-module, uart_sync_fifo: generic synchronous FIFO with params WIDTH and DEPTH and ports push/pop/din/dout/level/full/empty. It is reused later by uart_rx.
- FSM, baud counter and shift register stay in the top module.

Test Plan:
- Reset and idle: rst=1 for 3 cycles, then 20 cycles idle -> tx=1, tx_busy=0, s_ready=1, fifo_level=0 throughout.
- Single 8-bit frame (CLK_FREQ=1000000, BAUD_RATE=100000, DIV=10): push 0xA5 -> tx falls 2 cycles later and shows 0,1,0,1,0,0,1,0,1,1, each bit exactly 10 cycles. tx_busy is high for 100 cycles after the start bit begins.
- Back-to-back frames: push 0x01, 0xFF, 0x80 in consecutive cycles -> three frames with no idle gap between them, and the second start bit begins exactly at cycle 100 of the first frame.
- FIFO full (FIFO_DEPTH=4): hold s_valid=1 with data 0..7.
  - s_ready=0 once fifo_level=4, with the first word already popped into the shifter.
  - Exactly 8 words transmitted, in order, none lost or duplicated.
- Reset mid-frame: assert rst during data bit 3 of 0x3C with 2 words queued -> tx=1 the next cycle, fifo_level=0, no further frames sent.
- Parity and width (UART_TX_PARITY_EN, DATA_W=7, STOP_BITS=2, PARITY_ODD=1): send 0x55.
  - Parity bit = 1, since there are 4 ones and parity is odd.
  - Frame is 11 bits (110 cycles), ending in 2 stop bits of 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, baud divisor helper
// and the idle line level.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Clock cycles per bit; truncating division, caller keeps the result >= 2.
  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO. The head word is visible on dout while the
// FIFO is non-empty so a consumer can take it in the same cycle it pops.
// Push is ignored when full, pop is ignored when empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_level == (PTR_W+1)'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;
  assign dout  = r_mem[r_rd_ptr];

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage write; left unreset because clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: start bit, DATA_W data bits LSB first,
// optional parity bit, STOP_BITS stop bits, every bit DIV clocks long.
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit (PARITY_ODD
// selects odd parity) between the data bits and the stop bits.
// The tx register is loaded from the current state, so the line trails the
// FSM by one cycle; tx_busy is registered the same way and tracks the line.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  input  logic [DATA_W-1:0]             s_data,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV    = uart_div(CLK_FREQ, BAUD_RATE);
  localparam int BAUD_W = $clog2(DIV);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t    r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [BIT_W-1:0]  r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_tx;
  logic              r_busy;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_dout;
  logic [LVL_W-1:0]  w_level;
  logic              w_baud_end;
  logic              w_data_last;
  logic              w_stop_last;

  assign s_ready    = !w_full;
  assign w_push     = s_valid && !w_full;
  assign tx         = r_tx;
  assign tx_busy    = r_busy;
  assign fifo_level = w_level;

  assign w_baud_end  = (r_baud == BAUD_W'(DIV - 1));
  assign w_data_last = (r_bit == BIT_W'(DATA_W - 1));
  assign w_stop_last = (r_bit == BIT_W'(STOP_BITS - 1));

  // Pop when idle, or at the end of the last stop bit so frames run back to back.
  assign w_pop = !w_empty &&
                 ((r_state == IDLE) || ((r_state == STOP) && w_baud_end && w_stop_last));

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (s_data),
    .dout  (w_dout),
    .level (w_level),
    .full  (w_full),
    .empty (w_empty)
  );

`ifdef UART_TX_PARITY_EN
  logic r_par;

  // Parity of the word captured as it leaves the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_pop) begin
      r_par <= (^w_dout) ^ PARITY_ODD;
    end
  end
`endif

  // Frame sequencer: baud counter, bit counter, shifter and the tx/busy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= UART_IDLE_LEVEL;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= (r_state != IDLE) || (w_level != '0);
      r_baud <= ((r_state == IDLE) || w_baud_end) ? '0 : r_baud + 1'b1;
      case (r_state)
        IDLE: begin
          r_tx  <= UART_IDLE_LEVEL;
          r_bit <= '0;
          if (w_pop) begin
            r_shift <= w_dout;
            r_state <= START;
          end
        end
        START: begin
          r_tx <= 1'b0;
          if (w_baud_end) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          r_tx <= r_shift[0];
          if (w_baud_end) begin
            r_shift <= r_shift >> 1;
            if (w_data_last) begin
              r_bit <= '0;
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          r_tx <= r_par;
          if (w_baud_end) begin
            r_state <= STOP;
          end
        end
`endif
        STOP: begin
          r_tx <= UART_IDLE_LEVEL;
          if (w_baud_end) begin
            if (w_stop_last) begin
              r_bit <= '0;
              if (w_pop) begin
                r_shift <= w_dout;
                r_state <= START;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
